ua_pipe: RTL and testbench

- Parametrised, fully pipelined arithmetic/address unit for the Tomasulo back end.
- Sits between a reservation station (issue side) and the common data bus (CDB, result side).
- Accepts one tagged operation per cycle and returns result plus tag after LATENCY cycles.
- Supports CDB back-pressure (grant), whole-pipe flush, and signed overflow reporting.

---
 rtl/ua_pkg.sv | 20 ++
 rtl/ua_if.sv | 29 ++
 rtl/ua_alu.sv | 47 ++++
 rtl/ua_pipe.sv | 124 ++++++++++++
 tb/tb_ua_pipe.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ua_pkg.sv
// Shared op encodings and defaults for the ua_pipe arithmetic/address unit.
package ua_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_TAG_W = 3;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_LDA = 3'b011;
  localparam logic [2:0] OP_STA = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  function automatic logic is_addsub(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ua_if.sv
// Issue / CDB handshake bundle between reservation station, ua_pipe and the CDB.
interface ua_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 3
);
  logic                   start;
  logic [TAG_W-1:0]       ID_in;
  logic [WIDTH-1:0]       Dado1;
  logic [WIDTH-1:0]       Dado2;
  logic [2:0]             op;
  logic                   flush;
  logic                   cdb_grant;
  logic                   ready;
  logic                   busy;
  logic                   confirmacao;
  logic [TAG_W+WIDTH-1:0] Resultado;
  logic                   overflow;
  logic                   illegal;

  modport master (
    output start, ID_in, Dado1, Dado2, op, flush, cdb_grant,
    input  ready, busy, confirmacao, Resultado, overflow, illegal
  );

  modport slave (
    input  start, ID_in, Dado1, Dado2, op, flush, cdb_grant,
    output ready, busy, confirmacao, Resultado, overflow, illegal
  );
endinterface

// File: rtl/ua_alu.sv
// Combinational ALU for ua_pipe: add/sub/address, logic ops, signed set-less-than.
module ua_alu
  import ua_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]              op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic [WIDTH-1:0]        value,
  output logic                    overflow,
  output logic                    illegal
);

  logic signed [WIDTH-1:0] sum;
  logic signed [WIDTH-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x, y, r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x, y, r);
    return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  always_comb begin
    value    = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_ADD, OP_LDA, OP_STA: value = sum;
      OP_SUB:                 value = diff;
      OP_AND:                 value = a & b;
      OP_OR:                  value = a | b;
      OP_SLT:                 value = {{(WIDTH-1){1'b0}}, (a < b)};
      default:                illegal = 1'b1;
    endcase
    // Address ops wrap silently; only true arithmetic reports overflow.
    if (is_addsub(op)) begin
      overflow = (op == OP_ADD) ? add_ovf(a, b, sum) : sub_ovf(a, b, diff);
    end
  end

endmodule

// File: rtl/ua_pipe.sv
// Pipelined tagged arithmetic unit: LATENCY register stages, CDB back-pressure, flush.
module ua_pipe
  import ua_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int LATENCY = 3
) (
  input logic CLK,
  input logic CLR,
  ua_if.slave bus
);

  logic                    stall;
  logic                    ready_c;
  logic                    accept;
  logic                    vld_alu;
  logic                    vld_any;
  logic [TAG_W-1:0]        tag_alu;
  logic [2:0]              op_alu;
  logic signed [WIDTH-1:0] a_alu;
  logic signed [WIDTH-1:0] b_alu;
  logic [WIDTH-1:0]        val_alu;
  logic                    ovf_alu;
  logic                    ill_alu;

  logic                    conf_q;
  logic [TAG_W+WIDTH-1:0]  res_q;
  logic                    ovf_q;
  logic                    ill_q;

  assign stall   = conf_q && !bus.cdb_grant;
  assign ready_c = !bus.flush && !stall;
  assign accept  = bus.start && ready_c;

  generate
    if (LATENCY == 1) begin : g_direct
      assign vld_alu = accept;
      assign tag_alu = bus.ID_in;
      assign op_alu  = bus.op;
      assign a_alu   = bus.Dado1;
      assign b_alu   = bus.Dado2;
      assign vld_any = 1'b0;
    end else begin : g_stages
      localparam int N = LATENCY - 1;

      logic [N:1]              vld_p;
      logic [TAG_W-1:0]        tag_p [1:N];
      logic [2:0]              op_p  [1:N];
      logic signed [WIDTH-1:0] a_p   [1:N];
      logic signed [WIDTH-1:0] b_p   [1:N];

      // Stages 1..N: operand carry; bubbles hold in place on stall.
      always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
          vld_p <= '0;
        end else if (bus.flush) begin
          vld_p <= '0;
        end else if (!stall) begin
          vld_p[1] <= accept;
          for (int i = 2; i <= N; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge CLK) begin
        if (!stall) begin
          tag_p[1] <= bus.ID_in;
          op_p[1]  <= bus.op;
          a_p[1]   <= bus.Dado1;
          b_p[1]   <= bus.Dado2;
          for (int i = 2; i <= N; i++) begin
            tag_p[i] <= tag_p[i-1];
            op_p[i]  <= op_p[i-1];
            a_p[i]   <= a_p[i-1];
            b_p[i]   <= b_p[i-1];
          end
        end
      end

      assign vld_alu = vld_p[N];
      assign tag_alu = tag_p[N];
      assign op_alu  = op_p[N];
      assign a_alu   = a_p[N];
      assign b_alu   = b_p[N];
      assign vld_any = |vld_p;
    end
  endgenerate

  ua_alu #(.WIDTH(WIDTH)) u_alu (
    .op       (op_alu),
    .a        (a_alu),
    .b        (b_alu),
    .value    (val_alu),
    .overflow (ovf_alu),
    .illegal  (ill_alu)
  );

  // Output stage: presented result, held stable while the CDB withholds grant.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      conf_q <= 1'b0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else if (bus.flush) begin
      conf_q <= 1'b0;
    end else if (!stall) begin
      conf_q <= vld_alu;
      if (vld_alu) begin
        res_q <= {tag_alu, val_alu};
        ovf_q <= ovf_alu;
        ill_q <= ill_alu;
      end
    end
  end

  assign bus.ready       = ready_c;
  assign bus.busy        = vld_any || conf_q;
  assign bus.confirmacao = conf_q;
  assign bus.Resultado   = res_q;
  assign bus.overflow    = ovf_q;
  assign bus.illegal     = ill_q;

endmodule

// File: tb/tb_ua_pipe.sv
// Directed bench for ua_pipe: vector table streamed with grant high, plus stall/flush/reset sequences.
module tb_ua_pipe;
  import ua_pkg::*;

  localparam int WIDTH   = 16;
  localparam int TAG_W   = 3;
  localparam int LATENCY = 3;
  localparam int NV      = 14;

  logic clk = 1'b0;
  logic clr;
  int   checks   = 0;
  int   failures = 0;

  ua_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  ua_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .LATENCY(LATENCY)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic [15:0]      a;
    logic [15:0]      b;
    logic [15:0]      val;
    logic             ovf;
    logic             ill;
  } vec_t;

  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic s, input logic [2:0] o, input logic [TAG_W-1:0] t,
                       input logic [15:0] a, input logic [15:0] b);
    bus.start = s;
    bus.op    = o;
    bus.ID_in = t;
    bus.Dado1 = a;
    bus.Dado2 = b;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_res(input string name, input logic [TAG_W-1:0] t, input logic [15:0] v,
                         input logic o, input logic il);
    chk({name, ".conf"}, 32'(bus.confirmacao), 32'd1);
    chk({name, ".res"},  32'(bus.Resultado),   32'({t, v}));
    chk({name, ".ovf"},  32'(bus.overflow),    32'(o));
    chk({name, ".ill"},  32'(bus.illegal),     32'(il));
  endtask

  initial begin
    vecs[0]  = '{OP_ADD, 3'd2, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0};
    vecs[1]  = '{OP_SUB, 3'd1, 16'h000A, 16'h0003, 16'h0007, 1'b0, 1'b0};
    vecs[2]  = '{OP_AND, 3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
    vecs[3]  = '{OP_SLT, 3'd3, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0};
    vecs[4]  = '{OP_ADD, 3'd4, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0};
    vecs[5]  = '{OP_SUB, 3'd5, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0};
    vecs[6]  = '{OP_NOP, 3'd7, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1};
    vecs[7]  = '{OP_LDA, 3'd0, 16'h1234, 16'h0011, 16'h1245, 1'b0, 1'b0};
    vecs[8]  = '{OP_STA, 3'd6, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{OP_OR,  3'd1, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0};
    vecs[10] = '{OP_SLT, 3'd2, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{OP_ADD, 3'd3, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0};
    vecs[12] = '{OP_SUB, 3'd4, 16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b0};
    vecs[13] = '{OP_STA, 3'd5, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0};

    issue(1'b0, OP_NOP, '0, '0, '0);
    bus.flush     = 1'b0;
    bus.cdb_grant = 1'b1;
    clr           = 1'b0;

    // Reset
    tick();
    tick();
    chk("rst.conf", 32'(bus.confirmacao), 32'd0);
    chk("rst.res",  32'(bus.Resultado),   32'd0);
    chk("rst.ovf",  32'(bus.overflow),    32'd0);
    chk("rst.ill",  32'(bus.illegal),     32'd0);
    chk("rst.busy", 32'(bus.busy),        32'd0);
    clr = 1'b1;
    #1;
    chk("rst.ready", 32'(bus.ready), 32'd1);

    // Single ADD: result after three edges, one cycle only
    issue(1'b1, OP_ADD, 3'd2, 16'h0005, 16'h0003);
    tick();
    issue(1'b0, OP_NOP, '0, '0, '0);
    tick();
    chk("add.early", 32'(bus.confirmacao), 32'd0);
    tick();
    chk_res("add", 3'd2, 16'h0008, 1'b0, 1'b0);
    tick();
    chk("add.drop", 32'(bus.confirmacao), 32'd0);
    chk("add.busy", 32'(bus.busy),        32'd0);

    // Table stream, one issue per cycle
    for (int i = 0; i < NV + LATENCY; i++) begin
      int k;
      if (i < NV) issue(1'b1, vecs[i].op, vecs[i].tag, vecs[i].a, vecs[i].b);
      else        issue(1'b0, OP_NOP, '0, '0, '0);
      tick();
      k = i - (LATENCY - 1);
      if (k >= 0 && k < NV)
        chk_res($sformatf("vec%0d", k), vecs[k].tag, vecs[k].val, vecs[k].ovf, vecs[k].ill);
    end
    chk("stream.conf", 32'(bus.confirmacao), 32'd0);
    chk("stream.busy", 32'(bus.busy),        32'd0);

    // Back-pressure: three in flight, grant low, a fourth request held during stall
    bus.cdb_grant = 1'b0;
    issue(1'b1, OP_ADD, 3'd1, 16'h0100, 16'h0001);
    tick();
    issue(1'b1, OP_SUB, 3'd4, 16'h0050, 16'h0010);
    tick();
    issue(1'b1, OP_OR, 3'd6, 16'hA000, 16'h000A);
    tick();
    issue(1'b1, OP_AND, 3'd7, 16'hFFFF, 16'h1234);
    for (int s = 0; s < 4; s++) begin
      #1;
      chk($sformatf("stall%0d.ready", s), 32'(bus.ready), 32'd0);
      chk($sformatf("stall%0d.busy", s),  32'(bus.busy),  32'd1);
      chk_res($sformatf("stall%0d", s), 3'd1, 16'h0101, 1'b0, 1'b0);
      tick();
    end
    chk_res("stall.end", 3'd1, 16'h0101, 1'b0, 1'b0);
    bus.cdb_grant = 1'b1;
    tick();
    issue(1'b0, OP_NOP, '0, '0, '0);
    chk_res("drain.b", 3'd4, 16'h0040, 1'b0, 1'b0);
    tick();
    chk_res("drain.c", 3'd6, 16'hA00A, 1'b0, 1'b0);
    tick();
    chk_res("drain.d", 3'd7, 16'h1234, 1'b0, 1'b0);
    tick();
    chk("drain.conf", 32'(bus.confirmacao), 32'd0);
    chk("drain.busy", 32'(bus.busy),        32'd0);

    // Flush with two in flight and a simultaneous start
    issue(1'b1, OP_ADD, 3'd1, 16'h0001, 16'h0001);
    tick();
    issue(1'b1, OP_ADD, 3'd2, 16'h0002, 16'h0002);
    tick();
    issue(1'b1, OP_ADD, 3'd3, 16'h0003, 16'h0003);
    bus.flush = 1'b1;
    #1;
    chk("flush.ready", 32'(bus.ready), 32'd0);
    tick();
    bus.flush = 1'b0;
    issue(1'b0, OP_NOP, '0, '0, '0);
    chk("flush.busy", 32'(bus.busy),        32'd0);
    chk("flush.conf", 32'(bus.confirmacao), 32'd0);
    for (int s = 0; s < LATENCY; s++) begin
      tick();
      chk($sformatf("flush.quiet%0d", s), 32'(bus.confirmacao), 32'd0);
    end
    issue(1'b1, OP_SUB, 3'd5, 16'h0009, 16'h000A);
    tick();
    issue(1'b0, OP_NOP, '0, '0, '0);
    tick();
    tick();
    chk_res("post_flush", 3'd5, 16'hFFFF, 1'b0, 1'b0);
    tick();
    chk("post_flush.drop", 32'(bus.confirmacao), 32'd0);

    // Async reset while a result is presented under stall
    bus.cdb_grant = 1'b0;
    issue(1'b1, OP_LDA, 3'd3, 16'h1000, 16'h0234);
    tick();
    issue(1'b0, OP_NOP, '0, '0, '0);
    tick();
    tick();
    chk_res("pre_areset", 3'd3, 16'h1234, 1'b0, 1'b0);
    #2;
    clr = 1'b0;
    #1;
    chk("areset.conf", 32'(bus.confirmacao), 32'd0);
    chk("areset.res",  32'(bus.Resultado),   32'd0);
    chk("areset.busy", 32'(bus.busy),        32'd0);
    tick();
    clr = 1'b1;
    bus.cdb_grant = 1'b1;
    #1;
    chk("areset.ready", 32'(bus.ready), 32'd1);
    tick();
    chk("areset.idle", 32'(bus.confirmacao), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
